// File: rtl/sd_cmd_resp_deserializer_pkg.sv
// sd_cmd_pkg: shared definitions for the SD CMD-line response path.
// Holds the receiver state encoding, the standard response frame lengths,
// the CRC7 generator polynomial and the receive-index window that the CRC
// covers for each frame type. The command serializer reuses the CRC items.
package sd_cmd_pkg;

  // Receiver phases: waiting for an arm, hunting for the start bit,
  // shifting in the frame, and holding a finished result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } stateType;

  // R1/R3/R6/R7 responses are 48 bits, R2 is 136 bits.
  localparam int SHORT_BITS = 48;
  localparam int LONG_BITS  = 136;

  // CRC7 generator x^7 + x^3 + 1 without the implicit x^7 term.
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // CRC coverage expressed as receive indices (index 0 = start bit).
  // A short frame is covered from its start bit; an R2 frame skips its
  // 8 header bits. Both stop before the trailing CRC7 + end bit byte.
  localparam int SHORT_CRC_FIRST = 0;
  localparam int LONG_CRC_FIRST  = 8;
  localparam int CRC_TAIL_BITS   = 8;

endpackage

// File: rtl/sd_cmd_resp_deserializer_if.sv
// sd_cmd_resp_deserializer_if: handoff bundle between the host command FSM
// (master) and the response deserializer (slave).
//   start      arm request                         master -> slave
//   long_resp  0 = short frame, 1 = long frame     master -> slave
//   skip_crc   ignore the CRC7 comparison          master -> slave
//   ready      result consumed                     master -> slave
//   out        received frame, right-aligned       slave -> master
//   valid      result available                    slave -> master
//   busy       receiver not idle                   slave -> master
//   crc_err    CRC7 mismatch (with valid)          slave -> master
//   frame_err  bad transmission/end bit (with valid) slave -> master
//   timeout    no start bit seen (with valid)      slave -> master
interface sd_cmd_resp_deserializer_if #(
  parameter int MAX_BITS = 136
);

  logic                start;
  logic                long_resp;
  logic                skip_crc;
  logic                ready;
  logic [MAX_BITS-1:0] out;
  logic                valid;
  logic                busy;
  logic                crc_err;
  logic                frame_err;
  logic                timeout;

  modport master (
    output start, long_resp, skip_crc, ready,
    input  out, valid, busy, crc_err, frame_err, timeout
  );

  modport slave (
    input  start, long_resp, skip_crc, ready,
    output out, valid, busy, crc_err, frame_err, timeout
  );

endinterface

// File: rtl/sd_cmd_resp_deserializer_crc7.sv
// sd_crc7: serial MSB-first CRC7 (x^7 + x^3 + 1) accumulator, init 0.
//   clk     SD bus clock
//   reset   synchronous, active-high; clears the register
//   clear   synchronous clear at the start of a new frame
//   enable  fold bitIn into the CRC this cycle
//   bitIn   serial data bit
//   crc     current remainder
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bitIn,
  output logic [6:0] crc
);

  // Galois-style LFSR: the incoming bit is XORed with the outgoing MSB and
  // the result decides whether the polynomial taps are applied. Clear wins
  // over enable so a fresh frame always starts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{bitIn ^ crc[6]}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/sd_cmd_resp_deserializer.sv
// sd_cmd_resp_deserializer: captures an SD card response from the CMD line.
// After an arm request it hunts for the start bit, shifts the frame in
// MSB-first, then checks CRC7, transmission bit and end bit, or reports a
// timeout when no start bit arrives in time. The result is held until the
// command controller takes it with valid/ready.
//   clk    SD bus clock; in is sampled on its rising edge
//   reset  synchronous, active-high
//   in     serial CMD line, idle high
//   bus    handshake bundle (slave side): start/long_resp/skip_crc/ready in,
//          out/valid/busy/crc_err/frame_err/timeout out
module sd_cmd_resp_deserializer #(
  parameter int MAX_BITS   = 136,
  parameter int SHORT_BITS = 48,
  parameter int LONG_BITS  = 136,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 64,
  parameter int TO_W       = 7
) (
  input logic                       clk,
  input logic                       reset,
  input logic                       in,
  sd_cmd_resp_deserializer_if.slave bus
);

  import sd_cmd_pkg::*;

  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_BITS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  stateType            state;
  stateType            stateNext;
  logic [MAX_BITS-1:0] outReg;
  logic [MAX_BITS-1:0] shifted;
  logic                validReg;
  logic                busyReg;
  logic                crcErrReg;
  logic                frameErrReg;
  logic                timeoutReg;
  logic                longLat;
  logic                skipLat;
  logic [CNT_W-1:0]    bitCnt;
  logic [TO_W-1:0]     toCnt;
  logic [CNT_W-1:0]    lastIdx;
  logic [CNT_W-1:0]    crcFirst;
  logic [CNT_W-1:0]    crcLast;
  logic [CNT_W-1:0]    sampleIdx;
  logic                inCrcWindow;
  logic                lastBit;
  logic                txBit;
  logic [6:0]          crcValue;
  logic                crcClear;
  logic                crcEnable;

  // Frame geometry for the latched response type. sampleIdx is the receive
  // index of the bit sampled this cycle: the start bit is index 0 and is
  // taken in HUNT, every later bit in RECV where bitCnt already equals it.
  always_comb begin
    lastIdx     = longLat ? LONG_LAST : SHORT_LAST;
    crcFirst    = longLat ? CNT_W'(LONG_CRC_FIRST) : CNT_W'(SHORT_CRC_FIRST);
    crcLast     = lastIdx - CNT_W'(CRC_TAIL_BITS);
    sampleIdx   = (state == RECV) ? bitCnt : '0;
    inCrcWindow = (sampleIdx >= crcFirst) && (sampleIdx <= crcLast);
    lastBit     = (state == RECV) && (bitCnt == lastIdx);
    // On the end-bit edge outReg holds everything but the end bit, so the
    // transmission bit (second bit received) sits at LEN-3.
    txBit       = longLat ? outReg[LONG_BITS-3] : outReg[SHORT_BITS-3];
    shifted     = {outReg[MAX_BITS-2:0], in};
  end

  // Next-state and CRC control. The CRC is cleared on arm and fed only the
  // bits inside the coverage window, so it is already final well before the
  // end bit arrives.
  always_comb begin
    stateNext = state;
    crcClear  = 1'b0;
    crcEnable = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext = HUNT;
          crcClear  = 1'b1;
        end
      end
      HUNT: begin
        if (!in) begin
          stateNext = RECV;
          crcEnable = inCrcWindow;
        end else if (toCnt == TO_LAST) begin
          stateNext = DONE;
        end
      end
      RECV: begin
        crcEnable = inCrcWindow;
        if (lastBit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (bus.ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, shift register, counters and result flags. Flags are computed on
  // the edge that enters DONE so valid and the flags appear together, and
  // they are dropped on the handshake edge. out deliberately survives the
  // handshake and is only cleared by the next arm.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busyReg     <= 1'b0;
      outReg      <= '0;
      validReg    <= 1'b0;
      crcErrReg   <= 1'b0;
      frameErrReg <= 1'b0;
      timeoutReg  <= 1'b0;
      longLat     <= 1'b0;
      skipLat     <= 1'b0;
      bitCnt      <= '0;
      toCnt       <= '0;
    end else begin
      state   <= stateNext;
      busyReg <= (stateNext != IDLE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            longLat <= bus.long_resp;
            skipLat <= bus.skip_crc;
            outReg  <= '0;
            bitCnt  <= '0;
            toCnt   <= '0;
          end
        end
        HUNT: begin
          if (!in) begin
            outReg <= shifted;
            bitCnt <= CNT_W'(1);
          end else if (toCnt == TO_LAST) begin
            outReg      <= '0;
            validReg    <= 1'b1;
            timeoutReg  <= 1'b1;
            crcErrReg   <= 1'b0;
            frameErrReg <= 1'b0;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
        end
        RECV: begin
          outReg <= shifted;
          bitCnt <= bitCnt + CNT_W'(1);
          if (lastBit) begin
            validReg    <= 1'b1;
            timeoutReg  <= 1'b0;
            crcErrReg   <= (outReg[6:0] != crcValue) && !skipLat;
            frameErrReg <= txBit || !in;
          end
        end
        DONE: begin
          if (bus.ready) begin
            validReg    <= 1'b0;
            crcErrReg   <= 1'b0;
            frameErrReg <= 1'b0;
            timeoutReg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  sd_crc7 crcUnit (
    .clk    (clk),
    .reset  (reset),
    .clear  (crcClear),
    .enable (crcEnable),
    .bitIn  (in),
    .crc    (crcValue)
  );

  assign bus.out       = outReg;
  assign bus.valid     = validReg;
  assign bus.busy      = busyReg;
  assign bus.crc_err   = crcErrReg;
  assign bus.frame_err = frameErrReg;
  assign bus.timeout   = timeoutReg;

endmodule

// File: tb/tb_sd_cmd_resp_deserializer.sv
// tb_sd_cmd_resp_deserializer: scoreboard bench for the SD CMD response
// deserializer. Stimulus pushes the expected result of each transaction;
// a monitor compares every cycle the DUT holds valid and pops on handshake.
module tb_sd_cmd_resp_deserializer;

  localparam int MAX_BITS = 136;
  localparam int SHORT    = 48;
  localparam int LONG     = 136;

  typedef struct {
    logic [135:0] out;
    logic         crcErr;
    logic         frameErr;
    logic         timeout;
    string        name;
  } expType;

  logic   clk;
  logic   reset;
  logic   in;
  int     checks;
  int     errors;
  expType sbQueue[$];

  sd_cmd_resp_deserializer_if #(.MAX_BITS(MAX_BITS)) bus ();

  sd_cmd_resp_deserializer dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .bus   (bus)
  );

  // Free-running SD bus clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic getBit(logic [135:0] v, int idx);
    logic [135:0] s;
    s = v >> idx;
    return s[0];
  endfunction

  // CRC7 as the remainder of polynomial long division of the covered bits
  // (times x^7) by x^7 + x^3 + 1.
  function automatic logic [6:0] crcModel(logic [135:0] frame, int len);
    logic [134:0] w;
    int msb;
    int n;
    msb = (len == LONG) ? 127 : len - 1;
    n   = msb - 8 + 1;
    w   = '0;
    for (int i = 0; i < n; i++) begin
      if (getBit(frame, msb - i)) w = w | (135'd1 << (n + 6 - i));
    end
    for (int i = n + 6; i >= 7; i--) begin
      if (getBit(136'(w), i)) w = w ^ (135'h89 << (i - 7));
    end
    return w[6:0];
  endfunction

  function automatic expType modelResult(logic [135:0] frame, int len, logic skip, string name);
    expType e;
    e.out      = frame;
    e.crcErr   = (frame[7:1] != crcModel(frame, len)) && !skip;
    e.frameErr = getBit(frame, len - 2) || !frame[0];
    e.timeout  = 1'b0;
    e.name     = name;
    return e;
  endfunction

  function automatic logic [135:0] buildShort(logic [5:0] idx, logic [31:0] arg, logic badTx,
                                              logic [6:0] crcXor, logic endBit);
    logic [135:0] f;
    f        = '0;
    f[47:40] = {1'b0, badTx, idx};
    f[39:8]  = arg;
    f[7:1]   = crcModel(f, SHORT) ^ crcXor;
    f[0]     = endBit;
    return f;
  endfunction

  function automatic logic [135:0] buildLong(logic [119:0] cid, logic badTx,
                                             logic [6:0] crcXor, logic endBit);
    logic [135:0] f;
    f          = '0;
    f[135:128] = {1'b0, badTx, 6'h3F};
    f[127:8]   = cid;
    f[7:1]     = crcModel(f, LONG) ^ crcXor;
    f[0]       = endBit;
    return f;
  endfunction

  task automatic checkOutput(string name, logic [135:0] actual, logic [135:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every cycle the DUT presents valid, compare against the oldest
  // expected result; pop it when the handshake completes on the next edge.
  always @(negedge clk) begin
    if (!reset && bus.valid) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got valid=1 expected no pending result");
      end else begin
        checkOutput({sbQueue[0].name, "_out"}, bus.out, sbQueue[0].out);
        checkOutput({sbQueue[0].name, "_crc_err"}, 136'(bus.crc_err), 136'(sbQueue[0].crcErr));
        checkOutput({sbQueue[0].name, "_frame_err"}, 136'(bus.frame_err), 136'(sbQueue[0].frameErr));
        checkOutput({sbQueue[0].name, "_timeout"}, 136'(bus.timeout), 136'(sbQueue[0].timeout));
        if (bus.ready) void'(sbQueue.pop_front());
      end
    end
  end

  task automatic armDut(logic longResp, logic skipCrc);
    bus.start     = 1'b1;
    bus.long_resp = longResp;
    bus.skip_crc  = skipCrc;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.long_resp = 1'($urandom);
    bus.skip_crc  = 1'($urandom);
  endtask

  task automatic sendBits(logic [135:0] frame, int len, int idle);
    in = 1'b1;
    repeat (idle) begin @(posedge clk); #1; end
    for (int i = 0; i < len; i++) begin
      in = getBit(frame, len - 1 - i);
      @(posedge clk); #1;
    end
    in = 1'b1;
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!bus.valid && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!bus.valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_valid: got no valid after %0d cycles expected valid", cycles);
    end
  endtask

  task automatic finishResult(int hold);
    bus.ready = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    bus.ready = 1'b1;
    @(posedge clk); #1;
    bus.ready = 1'b0;
    checkOutput("post_handshake_valid", 136'(bus.valid), 136'(0));
    checkOutput("post_handshake_busy", 136'(bus.busy), 136'(0));
  endtask

  // One complete response: expectation pushed, arm, line driven, result
  // awaited (valid must already be up right after the end-bit edge).
  task automatic applyStimulus(string name, logic [135:0] frame, int len, logic skip,
                               int idle, int hold);
    int cycles;
    sbQueue.push_back(modelResult(frame, len, skip, name));
    armDut(len == LONG, skip);
    sendBits(frame, len, idle);
    waitValid(cycles);
    checkOutput({name, "_latency"}, 136'(cycles), 136'(0));
    finishResult(hold);
  endtask

  initial begin
    logic [135:0] r7Good;
    logic [135:0] r7Bad;
    logic [135:0] cidGood;
    logic [135:0] cidBadEnd;
    logic [135:0] f;
    logic [127:0] rnd;
    expType       e;
    int           cycles;
    int           fault;
    logic         isLong;
    logic         skip;

    checks        = 0;
    errors        = 0;
    r7Good        = 136'h08000001AA13;
    r7Bad         = 136'h08000001AA15;
    cidGood       = buildLong(120'h112233445566778899AABBCCDDEEFF, 1'b0, 7'h00, 1'b1);
    cidBadEnd     = cidGood;
    cidBadEnd[0]  = 1'b0;

    reset         = 1'b1;
    in            = 1'b1;
    bus.start     = 1'b0;
    bus.long_resp = 1'b0;
    bus.skip_crc  = 1'b0;
    bus.ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_busy", 136'(bus.busy), 136'(0));
    checkOutput("reset_valid", 136'(bus.valid), 136'(0));
    checkOutput("reset_out", bus.out, 136'(0));
    checkOutput("reset_crc_err", 136'(bus.crc_err), 136'(0));
    checkOutput("reset_frame_err", 136'(bus.frame_err), 136'(0));
    checkOutput("reset_timeout", 136'(bus.timeout), 136'(0));

    $display("[TB] short R7 frames");
    applyStimulus("r7_good", r7Good, SHORT, 1'b0, 5, 2);
    applyStimulus("r7_crc_bad", r7Bad, SHORT, 1'b0, 3, 1);
    applyStimulus("r7_crc_skip", r7Bad, SHORT, 1'b1, 0, 0);

    $display("[TB] no-response timeout");
    e.out = '0; e.crcErr = 1'b0; e.frameErr = 1'b0; e.timeout = 1'b1; e.name = "timeout";
    sbQueue.push_back(e);
    armDut(1'b0, 1'b0);
    waitValid(cycles);
    checkOutput("timeout_latency", 136'(cycles), 136'(64));
    finishResult(10);

    $display("[TB] long R2 frames");
    applyStimulus("r2_good", cidGood, LONG, 1'b0, 4, 1);
    applyStimulus("r2_bad_end", cidBadEnd, LONG, 1'b0, 2, 0);

    $display("[TB] reset in the middle of a frame");
    armDut(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in = getBit(r7Good, SHORT - 1 - i);
      @(posedge clk); #1;
    end
    in    = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_busy", 136'(bus.busy), 136'(0));
    checkOutput("midreset_valid", 136'(bus.valid), 136'(0));
    checkOutput("midreset_out", bus.out, 136'(0));
    applyStimulus("r7_after_reset", r7Good, SHORT, 1'b0, 2, 0);

    $display("[TB] start while busy");
    sbQueue.push_back(modelResult(r7Bad, SHORT, 1'b0, "start_busy"));
    armDut(1'b0, 1'b0);
    armDut(1'b1, 1'b1);
    sendBits(r7Bad, SHORT, 2);
    waitValid(cycles);
    checkOutput("start_busy_latency", 136'(cycles), 136'(0));

    $display("[TB] start during handshake, re-arm next cycle");
    bus.ready     = 1'b1;
    bus.start     = 1'b1;
    bus.long_resp = 1'b0;
    bus.skip_crc  = 1'b0;
    @(posedge clk); #1;
    checkOutput("handshake_start_busy", 136'(bus.busy), 136'(0));
    bus.ready = 1'b0;
    sbQueue.push_back(modelResult(r7Good, SHORT, 1'b0, "rearm"));
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("rearm_busy", 136'(bus.busy), 136'(1));
    sendBits(r7Good, SHORT, 3);
    waitValid(cycles);
    checkOutput("rearm_latency", 136'(cycles), 136'(0));
    finishResult(0);

    $display("[TB] randomized frames");
    for (int n = 0; n < 10; n++) begin
      isLong = 1'($urandom);
      skip   = 1'($urandom);
      fault  = $urandom_range(0, 3);
      rnd    = {$urandom, $urandom, $urandom, $urandom};
      if (isLong) begin
        f = buildLong(rnd[119:0], fault == 3,
                      (fault == 1) ? 7'($urandom_range(1, 127)) : 7'h00, fault != 2);
      end else begin
        f = buildShort(rnd[5:0], rnd[37:6], fault == 3,
                       (fault == 1) ? 7'($urandom_range(1, 127)) : 7'h00, fault != 2);
      end
      applyStimulus($sformatf("rand%0d", n), f, isLong ? LONG : SHORT, skip,
                    $urandom_range(0, 8), $urandom_range(0, 3));
    end

    checkOutput("scoreboard_drained", 136'(sbQueue.size()), 136'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
